peripheral_bin2bcd_gen: RTL and testbench
=========================================

// Module: peripheral_bin2bcd_gen
// PURPOSE
//  Parametrised memory-mapped binary-to-BCD converter peripheral on the CPU bus (cs/rd/wr/addr[4:2]).
//  Sequential double-dabble engine, one input bit per clock; generic input width and digit count.
//  Supports unsigned and two's-complement (signed) modes, a sticky DONE flag and a significant-digit count.
//  Sits beside the other bus peripherals and typically feeds display drivers.
// PARAMETERS
//  BIN_W       32  binary input width, 4..32
//  BCD_DIGITS  10  output digits, 1..16; must be >= ceil(BIN_W*log10(2)) (elaboration error otherwise)
// PORTS
//  clk     in   1   system clock, rising edge
//  rst     in   1   asynchronous, active-high reset
//  d_in    in   32  bus write data
//  cs      in   1   chip select
//  addr    in   3   register select, addr[4:2]
//  rd      in   1   read strobe (qualified by cs)
//  wr      in   1   write strobe (qualified by cs)
//  d_out   out  32  bus read data
// BEHAVIOUR
//  Registers (addr): 000 DATA (W, BIN_W LSBs used); 001 CTRL (W: bit0 START, bit1 SIGNED; R: {30'b0,SIGNED,1'b0});
//   010 STATUS (R: bit0 DONE, bit1 BUSY, bit2 NEG); 011 RES_LO (R: digits 7..0, 4b each, digit0 in [3:0]);
//   100 RES_HI (R: digits 15..8, zero above BCD_DIGITS); 101 NDIG (R: count of significant digits, 1..BCD_DIGITS).
//   Other addresses read 0; writes to them and to read-only registers are ignored.
//  Reset: DATA, SIGNED, DONE, BUSY, NEG, results = 0; NDIG = 1; d_out = 0; FSM -> IDLE.
//  Bus: write on posedge when cs&wr. d_out is registered: loaded at posedge with selected register when cs&rd,
//   else 0. Read data therefore appears 1 cycle after the strobe. cs&rd&wr together: write wins, d_out = 0.
//  FSM: IDLE -> (CTRL write with START=1) LOAD -> SHIFT (BIN_W cycles) -> FIN -> IDLE.
//   LOAD: snapshot DATA; in SIGNED mode with MSB=1, operand = two's-complement magnitude, NEG=1, else NEG=0;
//    clear BCD accumulator; DONE=0, BUSY=1.
//   SHIFT: each cycle add 3 to every digit >= 5, then shift left one bit from operand MSB; bit counter decrements.
//   FIN: copy accumulator to RES_LO/RES_HI, compute NDIG (index of highest non-zero digit + 1, min 1),
//    DONE=1, BUSY=0.
//  Latency: START write edge E0; results, DONE=1 and BUSY=0 visible after edge E0+BIN_W+2 (34 cycles at BIN_W=32).
//  START written while BUSY: ignored (SIGNED bit of that write also ignored). DATA writes while BUSY update DATA
//   but do not affect the running conversion. Results hold previous values until FIN.
//  DONE is sticky until next accepted START or reset; reading STATUS does not clear it.
//  SIGNED, most-negative input (e.g. 0x80000000) converts to magnitude 2^(BIN_W-1), NEG=1.
//  Reset asserted mid-conversion: immediate return to IDLE with all reset values; no partial result kept.
//  Same-cycle DATA write and START: impossible (one register per access); START uses DATA as of the edge.
// STRUCTURE
//  Shared package bin2bcd_pkg: register address localparams, CTRL/STATUS bit indices, FSM state encoding,
//   min-digit function used for the BCD_DIGITS check.
//  Sub-module bin2bcd_dd_core: FSM + double-dabble datapath (start/operand in, bcd/ndig/done out);
//   top holds bus decode, DATA/CTRL registers, sign handling and read mux.
// TESTING
//  Unsigned 0x00000FA0, START -> after 34 cycles DONE=1; RES_LO=0x00004000, RES_HI=0, NDIG=4, NEG=0.
//  Unsigned 0xFFFFFFFF -> RES_LO=0x94967295, RES_HI=0x00000042, NDIG=10.
//  SIGNED 0xFFFFFFFF -> RES_LO=1, NEG=1, NDIG=1; SIGNED 0x80000000 -> RES_LO=0x47483648, RES_HI=0x21, NEG=1.
//  DATA=0 -> RES_LO=0, NDIG=1, DONE=1; second START while BUSY (cycle 10) -> ignored, result and timing unchanged.
//  rst pulse at cycle 15 of conversion -> BUSY=DONE=0, results 0, NDIG=1; new START then completes normally.
//  BIN_W=16, BCD_DIGITS=5: 0xFFFF -> RES_LO=0x00065535 after 18 cycles; d_out 1-cycle read latency checked.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bin2bcd_pkg
// Purpose  : Shared definitions for the binary-to-BCD converter peripheral:
//            register addresses, CTRL/STATUS bit positions, FSM encoding and
//            the minimum-digit helper used to validate BCD_DIGITS.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package bin2bcd_pkg;

  // Register map, addr[4:2]
  localparam logic [2:0] c_addr_data   = 3'd0;
  localparam logic [2:0] c_addr_ctrl   = 3'd1;
  localparam logic [2:0] c_addr_status = 3'd2;
  localparam logic [2:0] c_addr_res_lo = 3'd3;
  localparam logic [2:0] c_addr_res_hi = 3'd4;
  localparam logic [2:0] c_addr_ndig   = 3'd5;

  // CTRL bits
  localparam int c_ctrl_start  = 0;
  localparam int c_ctrl_signed = 1;

  // STATUS bits
  localparam int c_stat_done = 0;
  localparam int c_stat_busy = 1;
  localparam int c_stat_neg  = 2;

  // Conversion FSM encoding
  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_load  = 2'd1;
  localparam logic [1:0] c_st_shift = 2'd2;
  localparam logic [1:0] c_st_fin   = 2'd3;

  // Decimal digits needed for the largest unsigned BIN_W-bit value.
  function automatic int min_digits(input int bin_w);
    longint unsigned v;
    int              n;
    v = (64'd1 << bin_w) - 64'd1;
    n = 1;
    while (v >= 64'd10) begin
      v = v / 64'd10;
      n = n + 1;
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_dd_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bin2bcd_dd_core
// Purpose  : Sequential double-dabble engine, one operand bit per clock.
//            IDLE -> LOAD -> SHIFT (BIN_W cycles) -> FIN -> IDLE.
// Ports    : clk, rst        clock / async active-high reset
//            i_start         start pulse, honoured only in IDLE
//            i_operand       unsigned magnitude to convert (captured on start)
//            i_neg           sign flag travelling with the operand
//            o_idle          FSM in IDLE (new start may be accepted)
//            o_busy/o_done   status flags (DONE sticky until next start)
//            o_neg           sign of the current/last conversion
//            o_bcd           packed BCD result, digit 0 in [3:0]
//            o_ndig          significant digit count, 1..BCD_DIGITS
// Revision : 1.0 - initial release
// ============================================================================
module bin2bcd_dd_core
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W      = 32,
  parameter int BCD_DIGITS = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic [BIN_W-1:0]        i_operand,
  input  logic                    i_neg,
  output logic                    o_idle,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_neg,
  output logic [4*BCD_DIGITS-1:0] o_bcd,
  output logic [4:0]              o_ndig
);

  localparam int c_bcd_w = 4 * BCD_DIGITS;
  localparam int c_cnt_w = $clog2(BIN_W + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(BIN_W);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  logic [1:0]         r_state;
  logic [BIN_W-1:0]   r_op;
  logic               r_neg_pend;
  logic [c_bcd_w-1:0] r_acc;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_busy;
  logic               r_done;
  logic               r_neg;
  logic [c_bcd_w-1:0] r_res;
  logic [4:0]         r_ndig;

  logic [c_bcd_w-1:0] w_acc_adj;
  logic [c_bcd_w-1:0] w_acc_next;
  logic [4:0]         w_ndig;

  // Add-3 correction on every digit that would overflow past 9 after doubling.
  for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit_adj
    assign w_acc_adj[4*gi +: 4] = (r_acc[4*gi +: 4] >= 4'd5) ?
                                  (r_acc[4*gi +: 4] + 4'd3) : r_acc[4*gi +: 4];
  end

  assign w_acc_next = {w_acc_adj[c_bcd_w-2:0], r_op[BIN_W-1]};

  // Highest non-zero digit index + 1; a zero result still reports one digit.
  always_comb begin
    w_ndig = 5'd1;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (r_acc[4*i +: 4] != 4'd0) w_ndig = 5'(i + 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= c_st_idle;
      r_op       <= '0;
      r_neg_pend <= 1'b0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_neg      <= 1'b0;
      r_res      <= '0;
      r_ndig     <= 5'd1;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (i_start) begin
            r_op       <= i_operand;
            r_neg_pend <= i_neg;
            r_state    <= c_st_load;
          end
        end
        c_st_load: begin
          r_acc   <= '0;
          r_cnt   <= c_cnt_init;
          r_busy  <= 1'b1;
          r_done  <= 1'b0;
          r_neg   <= r_neg_pend;
          r_state <= c_st_shift;
        end
        c_st_shift: begin
          r_acc <= w_acc_next;
          r_op  <= {r_op[BIN_W-2:0], 1'b0};
          r_cnt <= r_cnt - c_cnt_one;
          if (r_cnt == c_cnt_one) r_state <= c_st_fin;
        end
        c_st_fin: begin
          r_res   <= r_acc;
          r_ndig  <= w_ndig;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= c_st_idle;
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign o_idle = (r_state == c_st_idle);
  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_neg  = r_neg;
  assign o_bcd  = r_res;
  assign o_ndig = r_ndig;

endmodule
`default_nettype wire

// File: rtl/peripheral_bin2bcd_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : peripheral_bin2bcd_gen
// Purpose  : Memory-mapped binary-to-BCD converter peripheral. Holds the bus
//            decode, DATA/CTRL registers, sign handling and registered read
//            mux; the conversion itself runs in bin2bcd_dd_core.
// Ports    : clk, rst   clock / async active-high reset
//            d_in       bus write data
//            cs         chip select
//            addr       register select (addr[4:2])
//            rd, wr     read / write strobes, qualified by cs
//            d_out      registered read data (one cycle after the strobe)
// Revision : 1.0 - initial release
// ============================================================================
module peripheral_bin2bcd_gen
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W      = 32,
  parameter int BCD_DIGITS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d_in,
  input  logic        cs,
  input  logic [2:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [31:0] d_out
);

  if (BIN_W < 4 || BIN_W > 32) begin : g_chk_bin_w
    $error("peripheral_bin2bcd_gen: BIN_W must be 4..32");
  end
  if (BCD_DIGITS < 1 || BCD_DIGITS > 16) begin : g_chk_digits_range
    $error("peripheral_bin2bcd_gen: BCD_DIGITS must be 1..16");
  end
  if (BCD_DIGITS < min_digits(BIN_W)) begin : g_chk_digits_fit
    $error("peripheral_bin2bcd_gen: BCD_DIGITS too small for BIN_W");
  end

  logic [BIN_W-1:0]        r_data;
  logic                    r_signed;
  logic [31:0]             r_dout;

  logic                    w_wr;
  logic                    w_rd;
  logic                    w_idle;
  logic                    w_ctrl_wr;
  logic                    w_start;
  logic                    w_neg;
  logic [BIN_W-1:0]        w_operand;
  logic                    w_busy;
  logic                    w_done;
  logic                    w_neg_st;
  logic [4*BCD_DIGITS-1:0] w_bcd;
  logic [4:0]              w_ndig;
  logic [63:0]             w_res64;
  logic [31:0]             w_rdata;
  logic                    w_unused;

  assign w_wr = cs & wr;
  assign w_rd = cs & rd & ~wr;     // a simultaneous write wins over the read

  // CTRL writes (START and SIGNED alike) only take effect between conversions.
  assign w_ctrl_wr = w_wr & (addr == c_addr_ctrl) & w_idle;
  assign w_start   = w_ctrl_wr & d_in[c_ctrl_start];

  // Sign is judged with the SIGNED bit carried by the START write itself.
  assign w_neg     = d_in[c_ctrl_signed] & r_data[BIN_W-1];
  assign w_operand = w_neg ? ((~r_data) + {{(BIN_W-1){1'b0}}, 1'b1}) : r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data   <= '0;
      r_signed <= 1'b0;
    end else begin
      if (w_wr && (addr == c_addr_data)) r_data <= d_in[BIN_W-1:0];
      if (w_ctrl_wr) r_signed <= d_in[c_ctrl_signed];
    end
  end

  bin2bcd_dd_core #(
    .BIN_W      (BIN_W),
    .BCD_DIGITS (BCD_DIGITS)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_start),
    .i_operand (w_operand),
    .i_neg     (w_neg),
    .o_idle    (w_idle),
    .o_busy    (w_busy),
    .o_done    (w_done),
    .o_neg     (w_neg_st),
    .o_bcd     (w_bcd),
    .o_ndig    (w_ndig)
  );

  // Result padded to 16 digits so RES_HI reads zero above BCD_DIGITS.
  always_comb begin
    w_res64 = '0;
    w_res64[4*BCD_DIGITS-1:0] = w_bcd;
  end

  always_comb begin
    w_rdata = '0;
    case (addr)
      c_addr_ctrl:   w_rdata = {30'b0, r_signed, 1'b0};
      c_addr_status: w_rdata = {29'b0, w_neg_st, w_busy, w_done};
      c_addr_res_lo: w_rdata = w_res64[31:0];
      c_addr_res_hi: w_rdata = w_res64[63:32];
      c_addr_ndig:   w_rdata = {27'b0, w_ndig};
      default:       w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_dout <= '0;
    else     r_dout <= w_rd ? w_rdata : 32'd0;
  end

  assign d_out = r_dout;

  // Upper write-data bits are unused when BIN_W < 32.
  assign w_unused = &{1'b0, d_in};

endmodule
`default_nettype wire

// File: tb/tb_peripheral_bin2bcd_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_peripheral_bin2bcd_gen
// Purpose  : Self-checking bench for peripheral_bin2bcd_gen. Two instances:
//            BIN_W=32/BCD_DIGITS=10 and BIN_W=16/BCD_DIGITS=5. Reads push
//            their hand-computed expected value into a scoreboard queue; a
//            monitor pops and compares when the registered read data appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_peripheral_bin2bcd_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] d_in;
  logic        cs0, cs1;
  logic [2:0]  addr;
  logic        rd, wr;
  logic [31:0] dout0, dout1;

  always #5 clk = ~clk;

  peripheral_bin2bcd_gen #(.BIN_W(32), .BCD_DIGITS(10)) u_dut0 (
    .clk(clk), .rst(rst), .d_in(d_in), .cs(cs0), .addr(addr),
    .rd(rd), .wr(wr), .d_out(dout0)
  );

  peripheral_bin2bcd_gen #(.BIN_W(16), .BCD_DIGITS(5)) u_dut1 (
    .clk(clk), .rst(rst), .d_in(d_in), .cs(cs1), .addr(addr),
    .rd(rd), .wr(wr), .d_out(dout1)
  );

  typedef struct {
    string       name;
    logic [31:0] exp;
    bit          sel;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  logic rd_seen = 1'b0;

  // Read data is valid on d_out one edge after a qualified read strobe.
  always @(posedge clk) rd_seen <= (cs0 | cs1) & rd;

  always @(negedge clk) begin
    if (rd_seen) begin
      checks = checks + 1;
      if (sb_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_read: no expected value queued");
      end else begin
        exp_t        e;
        logic [31:0] act;
        e   = sb_q.pop_front();
        act = e.sel ? dout1 : dout0;
        if (act !== e.exp) begin
          errors = errors + 1;
          $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic idle_bus();
    cs0 = 1'b0; cs1 = 1'b0; rd = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_wr(input bit sel, input logic [2:0] a, input logic [31:0] d);
    cs0 = ~sel; cs1 = sel; wr = 1'b1; rd = 1'b0; addr = a; d_in = d;
    @(posedge clk); #1;
    idle_bus();
  endtask

  task automatic bus_rd(input bit sel, input logic [2:0] a, input logic [31:0] e,
                        input string name);
    exp_t x;
    x.name = name; x.exp = e; x.sel = sel;
    sb_q.push_back(x);
    cs0 = ~sel; cs1 = sel; rd = 1'b1; wr = 1'b0; addr = a;
    @(posedge clk); #1;
    idle_bus();
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Full conversion with the exact-latency DONE boundary check.
  task automatic convert(input bit sel, input logic [31:0] data, input bit sgn,
                         input logic [31:0] lo, input logic [31:0] hi,
                         input logic [31:0] ndig, input bit neg, input string tag);
    int lat;
    lat = sel ? 18 : 34;
    bus_wr(sel, 3'd0, data);
    bus_wr(sel, 3'd1, {30'b0, sgn, 1'b1});
    wait_cyc(lat - 1);
    bus_rd(sel, 3'd2, {29'b0, neg, 2'b10}, {tag, "_status_before_done"});
    bus_rd(sel, 3'd2, {29'b0, neg, 2'b01}, {tag, "_status_done"});
    bus_rd(sel, 3'd3, lo,   {tag, "_res_lo"});
    bus_rd(sel, 3'd4, hi,   {tag, "_res_hi"});
    bus_rd(sel, 3'd5, ndig, {tag, "_ndig"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; d_in = '0; addr = '0;
    idle_bus();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    bus_rd(1'b0, 3'd2, 32'h0, "rst_status");
    bus_rd(1'b0, 3'd3, 32'h0, "rst_res_lo");
    bus_rd(1'b0, 3'd5, 32'h1, "rst_ndig");
    bus_rd(1'b0, 3'd1, 32'h0, "rst_ctrl");
    bus_rd(1'b1, 3'd5, 32'h1, "rst_ndig_w16");

    // Unsigned / signed conversions at BIN_W=32
    convert(1'b0, 32'h00000FA0, 1'b0, 32'h00004000, 32'h0, 32'd4, 1'b0, "u_fa0");
    convert(1'b0, 32'hFFFFFFFF, 1'b0, 32'h94967295, 32'h42, 32'd10, 1'b0, "u_max");
    convert(1'b0, 32'hFFFFFFFF, 1'b1, 32'h1, 32'h0, 32'd1, 1'b1, "s_m1");
    bus_rd(1'b0, 3'd1, 32'h2, "ctrl_signed");
    convert(1'b0, 32'h80000000, 1'b1, 32'h47483648, 32'h21, 32'd10, 1'b1, "s_min");

    // Reset during a conversion: everything back to reset values
    bus_wr(1'b0, 3'd0, 32'd12345);
    bus_wr(1'b0, 3'd1, 32'h1);
    wait_cyc(14);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus_rd(1'b0, 3'd2, 32'h0, "midrst_status");
    bus_rd(1'b0, 3'd3, 32'h0, "midrst_res_lo");
    bus_rd(1'b0, 3'd4, 32'h0, "midrst_res_hi");
    bus_rd(1'b0, 3'd5, 32'h1, "midrst_ndig");
    convert(1'b0, 32'd12345, 1'b0, 32'h00012345, 32'h0, 32'd5, 1'b0, "after_rst");

    // Zero input, with a DATA write and an ignored START+SIGNED while busy
    bus_wr(1'b0, 3'd0, 32'h0);
    bus_wr(1'b0, 3'd1, 32'h1);
    wait_cyc(8);
    bus_wr(1'b0, 3'd0, 32'h00001234);
    bus_wr(1'b0, 3'd1, 32'h3);
    wait_cyc(23);
    bus_rd(1'b0, 3'd2, 32'h2, "zero_status_before_done");
    bus_rd(1'b0, 3'd2, 32'h1, "zero_status_done");
    bus_rd(1'b0, 3'd3, 32'h0, "zero_res_lo");
    bus_rd(1'b0, 3'd5, 32'h1, "zero_ndig");
    bus_rd(1'b0, 3'd1, 32'h0, "zero_ctrl_signed_ignored");
    bus_rd(1'b0, 3'd2, 32'h1, "done_sticky");

    // Unmapped / write-only reads, and write-wins on rd&wr
    bus_rd(1'b0, 3'd0, 32'h0, "read_data_reg");
    bus_rd(1'b0, 3'd7, 32'h0, "read_unmapped");
    cs0 = 1'b1; rd = 1'b1; wr = 1'b1; addr = 3'd5; d_in = 32'hFFFFFFFF;
    begin
      exp_t x;
      x.name = "rd_wr_collision"; x.exp = 32'h0; x.sel = 1'b0;
      sb_q.push_back(x);
    end
    @(posedge clk); #1;
    idle_bus();
    bus_rd(1'b0, 3'd5, 32'h1, "ndig_not_written");

    // BIN_W=16 instance
    convert(1'b1, 32'h0000FFFF, 1'b0, 32'h00065535, 32'h0, 32'd5, 1'b0, "w16_max");
    convert(1'b1, 32'h00008000, 1'b1, 32'h00032768, 32'h0, 32'd5, 1'b1, "w16_smin");
    convert(1'b1, 32'hABCD0064, 1'b0, 32'h00000100, 32'h0, 32'd3, 1'b0, "w16_upper_ignored");

    wait_cyc(3);
    checks = checks + 1;
    if (sb_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
